// File: rtl/traffic_pkg.sv
// Shared types, defaults and light decoding for the highway/farm-road intersection controller.
package traffic_pkg;

  typedef enum logic [1:0] {
    RED    = 2'b00,
    YELLOW = 2'b01,
    GREEN  = 2'b10
  } light_t;

  typedef enum logic [2:0] {
    INIT_AR = 3'd0,
    HG      = 3'd1,
    HY      = 3'd2,
    AR1     = 3'd3,
    FG      = 3'd4,
    FY      = 3'd5,
    AR2     = 3'd6
  } state_t;

  localparam int DEF_SYNC_STAGES  = 2;
  localparam int DEF_FARM_MAX_EXT = 2;
  // Extension counter width; FARM_MAX_EXT must not exceed 2**EXT_W - 1.
  localparam int EXT_W            = 4;

  typedef struct packed {
    state_t           state;
    logic             armed;
    logic             min_done;
    logic             ped_pending;
    logic [EXT_W-1:0] ext_cnt;
  } dbg_t;

  function automatic logic is_long_state(state_t s);
    return (s == HG) || (s == FG);
  endfunction

  function automatic light_t hwy_of(state_t s);
    case (s)
      HG:      return GREEN;
      HY:      return YELLOW;
      default: return RED;
    endcase
  endfunction

  function automatic light_t farm_of(state_t s);
    case (s)
      FG:      return GREEN;
      FY:      return YELLOW;
      default: return RED;
    endcase
  endfunction

endpackage

// File: rtl/traffic_ctrl_fsm_if.sv
// Controller <-> phase-timer command/timeout interface.
interface traffic_ctrl_fsm_if;
  // start_long/start_short are single-cycle commands that arm the timer; long_to/short_to
  // may be pulses or sticky levels and are only honoured by the controller while armed.
  logic start_long;
  logic start_short;
  logic long_to;
  logic short_to;

  modport master (output start_long, output start_short, input long_to, input short_to);
  modport slave  (input start_long, input start_short, output long_to, output short_to);
endinterface

// File: rtl/sync_edge.sv
// Multi-flop synchroniser for an asynchronous level, plus a rising-edge strobe on its output.
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic rise
);

  logic [STAGES-1:0] sh;
  logic              prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      sh   <= '0;
      prev <= 1'b0;
    end else begin
      sh   <= {sh[STAGES-2:0], din};
      prev <= sh[STAGES-1];
    end
  end

  assign dout = sh[STAGES-1];
  assign rise = sh[STAGES-1] & ~prev;

endmodule

// File: rtl/traffic_ctrl_fsm.sv
// Intersection sequencer: drives both light heads and the walk lamp, and arms the phase timer
// on every state entry (and on each farm-green extension).
module traffic_ctrl_fsm
  import traffic_pkg::*;
#(
  parameter int SYNC_STAGES  = DEF_SYNC_STAGES,
  parameter int FARM_MAX_EXT = DEF_FARM_MAX_EXT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      car_farm,
  input  logic                      ped_req,
  traffic_ctrl_fsm_if.master        tmr,
  output light_t                    hwy_light,
  output light_t                    farm_light,
  output logic                      ped_walk,
  output dbg_t                      dbg
);

  state_t           state, state_nxt;
  logic             armed, min_done, min_done_nxt;
  logic             ped_pending, ped_pending_nxt;
  logic [EXT_W-1:0] ext_cnt, ext_cnt_nxt;
  logic             car_s, car_rise, ped_s, ped_rise;
  logic             long_q, short_q, extend, entering, boot;
  logic             issue_long, issue_short;
  logic             unused_sync;

  sync_edge #(.STAGES(SYNC_STAGES)) u_car_sync (
    .clk (clk), .rst (rst), .din (car_farm), .dout (car_s), .rise (car_rise)
  );

  sync_edge #(.STAGES(SYNC_STAGES)) u_ped_sync (
    .clk (clk), .rst (rst), .din (ped_req), .dout (ped_s), .rise (ped_rise)
  );

  assign unused_sync = car_rise ^ ped_s;

  // Timeouts count only after the timer has been armed for at least one cycle.
  assign long_q  = armed & tmr.long_to;
  assign short_q = armed & tmr.short_to;

  always_comb begin
    state_nxt       = state;
    min_done_nxt    = min_done;
    ext_cnt_nxt     = ext_cnt;
    ped_pending_nxt = ped_pending | ped_rise;
    extend          = 1'b0;
    case (state)
      INIT_AR: if (short_q) state_nxt = HG;
      HG: begin
        if (long_q) min_done_nxt = 1'b1;
        if (min_done && (car_s || ped_pending)) state_nxt = HY;
      end
      HY:  if (short_q) state_nxt = AR1;
      AR1: if (short_q) state_nxt = FG;
      FG: begin
        if (long_q) begin
          if (car_s && (ext_cnt < EXT_W'(FARM_MAX_EXT))) begin
            ext_cnt_nxt = ext_cnt + EXT_W'(1);
            extend      = 1'b1;
          end else begin
            state_nxt = FY;
          end
        end
      end
      FY:  if (short_q) state_nxt = AR2;
      AR2: if (short_q) state_nxt = HG;
      default: state_nxt = INIT_AR;
    endcase

    entering = (state_nxt != state);
    if (state_nxt != HG) min_done_nxt = 1'b0;
    // Granting the walk wins over a press arriving in the same cycle.
    if (entering && (state_nxt == FG)) begin
      ext_cnt_nxt     = '0;
      ped_pending_nxt = 1'b0;
    end

    // Only right after reset are armed and both starts low together.
    boot        = ~armed & ~tmr.start_long & ~tmr.start_short;
    issue_long  = (entering && is_long_state(state_nxt)) || extend;
    issue_short = (entering && !is_long_state(state_nxt)) || boot;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= INIT_AR;
      hwy_light       <= RED;
      farm_light      <= RED;
      ped_walk        <= 1'b0;
      tmr.start_long  <= 1'b0;
      tmr.start_short <= 1'b0;
      armed           <= 1'b0;
      min_done        <= 1'b0;
      ped_pending     <= 1'b0;
      ext_cnt         <= '0;
    end else begin
      state           <= state_nxt;
      hwy_light       <= hwy_of(state_nxt);
      farm_light      <= farm_of(state_nxt);
      ped_walk        <= (state_nxt == FG);
      tmr.start_long  <= issue_long;
      tmr.start_short <= issue_short;
      armed           <= ~(issue_long | issue_short);
      min_done        <= min_done_nxt;
      ped_pending     <= ped_pending_nxt;
      ext_cnt         <= ext_cnt_nxt;
    end
  end

  assign dbg = '{state: state, armed: armed, min_done: min_done,
                 ped_pending: ped_pending, ext_cnt: ext_cnt};

endmodule

// File: doc/traffic_ctrl_fsm.md
Name: traffic_ctrl_fsm

Overview:
- Highway/farm-road intersection controller that sits directly upstream of the phase timer.
- Issues one-cycle start commands to the timer (long = green phase, short = yellow/all-red phase) and consumes the timer's long/short timeout indications.
- Drives both light heads and the pedestrian walk lamp.
- Synchronises the farm-road car sensor and latches pedestrian requests.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the car_farm and ped_req synchronisers (min 2).
- FARM_MAX_EXT, 2, maximum extra long periods farm green may extend while a car is still present (0 = no extension).

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- car_farm  in  1  async farm-road vehicle sensor, level
- ped_req  in  1  async pedestrian button, level or pulse
- long_to  in  1  timer long-period timeout (level or pulse)
- short_to  in  1  timer short-period timeout (level or pulse)
- start_long  out  1  one-cycle pulse: arm timer long period
- start_short  out  1  one-cycle pulse: arm timer short period
- hwy_light  out  2  highway head, light_t encoding
- farm_light  out  2  farm head, light_t encoding
- ped_walk  out  1  walk lamp for crossing the highway

Behaviour:
- One clock domain: clk. Reset is synchronous and active-high on rst. All outputs are registered.
- Reset values:
  - state = INIT_AR
  - hwy_light = farm_light = RED
  - ped_walk = 0, start_long = 0, start_short = 0
  - ext_cnt = 0, ped_pending = 0, armed = 0
  - synchronisers cleared
- States and lights:
  - INIT_AR (R/R), HG (G/R), HY (Y/R), AR1 (R/R), FG (R/G, ped_walk = 1), FY (R/Y), AR2 (R/R).
- Entry pulse: the registered start output goes high for exactly one cycle in the first cycle the new state is presented.
  - start_long on HG and FG entry, and on each FG extension.
  - start_short on INIT_AR, HY, AR1, FY and AR2 entry.
  - First start_short appears in the first cycle after rst deasserts.
- armed qualifier:
  - armed clears in the cycle a start pulse is issued and sets in the following cycle.
  - Timeouts are honoured only while armed = 1 and only if the type matches the state: long_to in HG/FG, short_to in the others.
  - This rejects stale sticky timeout levels. Mismatched timeouts are ignored.
- Transitions (next state is visible the cycle after the qualified event):
  - INIT_AR: short_to -> HG.
  - HG: a qualified long_to sets min_done.
    - Leave to HY in the first cycle with min_done = 1 and (car_s = 1 or ped_pending = 1).
    - Otherwise hold HG indefinitely with no re-arm.
    - min_done clears on HG exit.
  - HY: short_to -> AR1.
  - AR1: short_to -> FG. ext_cnt clears on FG entry.
  - FG: on long_to:
    - if car_s = 1 and ext_cnt < FARM_MAX_EXT: ext_cnt++, re-issue start_long, stay in FG;
    - else go to FY.
  - FY: short_to -> AR2.
  - AR2: short_to -> HG.
- Pedestrian:
  - ped_pending sets on a rising edge of synchronised ped_req.
  - ped_pending clears on FG entry.
  - Same-cycle set and clear: clear wins, because the walk is being granted.
  - A press during FG is latched for the next cycle.
- car_s and ped_s are the outputs of SYNC_STAGES-deep synchronisers; added latency is SYNC_STAGES cycles.
- Asserting rst in any state returns all registers to reset values on the next edge. No start pulse is issued while rst = 1.
- Illegal state encoding goes to INIT_AR with lights RED.
- Invariant: the two heads are never simultaneously non-RED.

Decomposition:
- Package traffic_pkg:
  - light_t enum: RED = 2'b00, YELLOW = 2'b01, GREEN = 2'b10.
  - state_t enum for the seven states.
  - Shared default constants for SYNC_STAGES and FARM_MAX_EXT.
- Sub-module sync_edge: SYNC_STAGES-deep synchroniser plus rising-edge detector, instantiated twice.

Test Plan:
- Reset release, no demand:
  - start_short pulses in cycle 1;
  - short_to after 5 cycles -> HG with start_long pulse;
  - long_to -> stays HG (G/R) for 100 cycles, no further start pulse.
- car_farm = 1 after HG min_done, FARM_MAX_EXT = 2, car held:
  - HY -> AR1 -> FG;
  - exactly 2 re-issued start_long pulses, then FY on the 3rd long_to;
  - then AR2 -> HG.
- Single 1-cycle ped_req during HG after min_done:
  - HY within SYNC_STAGES + 2 cycles;
  - ped_walk = 1 only during FG;
  - ped_pending = 0 after FG entry.
- long_to held high continuously: each green lasts one armed check only; long_to asserted during HY is ignored (no state change).
- ped_req edge coincident with FG entry: pending stays 0. ped_req in FG: pending = 1, next cycle is served.
- rst asserted mid-FG: next cycle lights R/R, ped_walk = 0, state INIT_AR, no start pulse until rst drops.
